// File: rtl/tx_preamble_framer_pkg.sv
// Shared state encodings and default frame geometry for the TX chain and its bench.
package tx_preamble_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } tx_state_t;

  localparam int          DEF_PRE_LEN  = 16;
  localparam int          DEF_PAY_LEN  = 64;
  localparam int          DEF_GAP_LEN  = 4;
  localparam logic [31:0] DEF_PRE_WORD = 32'h0000F0F0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tx_preamble_framer_sym_counter.sv
// Loadable down-counter shared by all framer phases; stops at zero, flags terminal count.
module tx_sym_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/tx_preamble_framer.sv
// Frames a preamble, fixed-length payload and silent gap onto a symbol-rate tick.
// state | meaning: IDLE wait/latch start | PREAMBLE send PRE_WORD MSB-first | PAYLOAD pass i_data | GAP silent slots, then o_done
module tx_preamble_framer
  import tx_preamble_framer_pkg::*;
#(
  parameter int          PRE_LEN  = DEF_PRE_LEN,
  parameter logic [31:0] PRE_WORD = DEF_PRE_WORD,
  parameter int          PAY_LEN  = DEF_PAY_LEN,
  parameter int          GAP_LEN  = DEF_GAP_LEN
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_valid,
  input  logic i_start,
  input  logic i_data,
  input  logic i_data_valid,
  output logic o_data_ready,
  output logic o_symbol,
  output logic o_sym_valid,
  output logic o_busy,
  output logic o_done,
  output logic o_underrun
);

  localparam int CNT_W = $clog2(max3(PRE_LEN, PAY_LEN, GAP_LEN) + 1);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] LD_PAY = CNT_W'(PAY_LEN - 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(GAP_LEN - 1);

  tx_state_t r_state, w_state_nxt;
  logic r_start_pend, w_start_pend_nxt;
  logic r_symbol, w_symbol_nxt;
  logic r_sym_valid, w_sym_valid_nxt;
  logic r_done, w_done_nxt;
  logic r_underrun, w_underrun_nxt;

  logic             w_tick;
  logic             w_load;
  logic             w_dec;
  logic             w_tc;
  logic             w_pre_bit;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;

  assign w_tick    = i_valid && i_enable;
  assign w_pre_bit = |(PRE_WORD & (32'd1 << w_count));

  tx_sym_counter #(.W(CNT_W)) u_cnt (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_start_pend <= 1'b0;
      r_symbol     <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_pend <= w_start_pend_nxt;
      r_symbol     <= w_symbol_nxt;
      r_sym_valid  <= w_sym_valid_nxt;
      r_done       <= w_done_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_start_pend_nxt = r_start_pend;
    w_symbol_nxt     = r_symbol;
    w_sym_valid_nxt  = 1'b0;
    w_done_nxt       = 1'b0;
    w_underrun_nxt   = r_underrun;
    w_load           = 1'b0;
    w_load_val       = '0;
    w_dec            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A start is only latched here; any tick in this cycle is deliberately dropped.
        if (i_enable) begin
          if (r_start_pend) begin
            w_state_nxt      = ST_PREAMBLE;
            w_start_pend_nxt = 1'b0;
            w_load           = 1'b1;
            w_load_val       = LD_PRE;
          end else if (i_start) begin
            w_start_pend_nxt = 1'b1;
            w_underrun_nxt   = 1'b0;
          end
        end
      end
      ST_PREAMBLE: begin
        if (w_tick) begin
          w_symbol_nxt    = w_pre_bit;
          w_sym_valid_nxt = 1'b1;
          if (w_tc) begin
            w_state_nxt = ST_PAYLOAD;
            w_load      = 1'b1;
            w_load_val  = LD_PAY;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_tick) begin
          w_symbol_nxt    = i_data_valid & i_data;
          w_sym_valid_nxt = 1'b1;
          if (!i_data_valid) w_underrun_nxt = 1'b1;
          if (w_tc) begin
            w_state_nxt = ST_GAP;
            w_load      = 1'b1;
            w_load_val  = LD_GAP;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (w_tc) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_data_ready = (r_state == ST_PAYLOAD) && w_tick;
  assign o_symbol     = r_symbol;
  assign o_sym_valid  = r_sym_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_tx_preamble_framer.sv
// Directed bench for tx_preamble_framer: PRE_LEN=16, PRE_WORD=F0F0, PAY_LEN=8, GAP_LEN=4, tick every 4 clocks.
module tb_tx_preamble_framer;
  import tx_preamble_framer_pkg::*;

  logic clock = 1'b0;
  logic i_reset, i_enable, i_valid, i_start, i_data, i_data_valid;
  logic o_data_ready, o_symbol, o_sym_valid, o_busy, o_done, o_underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pre_exp;
  logic [7:0]  pay_bits;

  always #5 clock = ~clock;

  tx_preamble_framer #(
    .PRE_LEN  (16),
    .PRE_WORD (32'h0000F0F0),
    .PAY_LEN  (8),
    .GAP_LEN  (4)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_valid      (i_valid),
    .i_start      (i_start),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_symbol     (o_symbol),
    .o_sym_valid  (o_sym_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_underrun   (o_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Three quiet clocks then one tick clock; samples ready during the tick, symbol after it.
  task automatic do_tick(input logic d, input logic dv, output logic rdy_quiet,
                         output logic rdy, output logic sv, output logic sym);
    repeat (3) cyc();
    rdy_quiet = o_data_ready;
    i_valid = 1'b1; i_data = d; i_data_valid = dv;
    #1 rdy = o_data_ready;
    cyc();
    sv  = o_sym_valid;
    sym = o_symbol;
    i_valid = 1'b0; i_data = 1'b0; i_data_valid = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    cyc();
    chk({tag, "_busy_after_start"}, o_busy, 1);
  endtask

  task automatic pre_ticks(input string tag, input int hi, input int lo);
    logic rq, r, sv, sym;
    for (int i = hi; i >= lo; i--) begin
      do_tick(1'b0, 1'b0, rq, r, sv, sym);
      chk($sformatf("%s_pre%0d_sym", tag, i), sym, pre_exp[i]);
      chk($sformatf("%s_pre%0d_sv", tag, i), sv, 1);
      chk($sformatf("%s_pre%0d_rdy", tag, i), r, 0);
    end
  endtask

  task automatic pay_ticks(input string tag, input int from, input int to, input int bad_idx);
    logic rq, r, sv, sym, dv, bit_i;
    for (int i = from; i <= to; i++) begin
      dv    = (i != bad_idx);
      bit_i = pay_bits[7-i];
      do_tick(bit_i, dv, rq, r, sv, sym);
      chk($sformatf("%s_pay%0d_sym", tag, i), sym, dv ? bit_i : 1'b0);
      chk($sformatf("%s_pay%0d_sv", tag, i), sv, 1);
      chk($sformatf("%s_pay%0d_rdy", tag, i), r, 1);
      chk($sformatf("%s_pay%0d_rdy_quiet", tag, i), rq, 0);
    end
  endtask

  task automatic gap_ticks(input string tag);
    logic rq, r, sv, sym;
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b0, 1'b0, rq, r, sv, sym);
      chk($sformatf("%s_gap%0d_sv", tag, i), sv, 0);
      chk($sformatf("%s_gap%0d_done", tag, i), o_done, (i == 3) ? 1 : 0);
      chk($sformatf("%s_gap%0d_busy", tag, i), o_busy, (i == 3) ? 0 : 1);
    end
    cyc();
    chk({tag, "_done_one_cycle"}, o_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rq, r, sv, sym, seen;
    pre_exp  = 16'hF0F0;
    pay_bits = 8'b10110010;
    i_reset = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_start = 1'b0;
    i_data = 1'b0; i_data_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_symbol", o_symbol, 0);
    chk("rst_sym_valid", o_sym_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_data_ready", o_data_ready, 0);
    i_reset = 1'b1;
    repeat (2) cyc();

    // Frame 1: clean preamble and payload.
    start_frame("f1");
    do_tick(1'b0, 1'b0, rq, r, sv, sym);
    chk("f1_pre15_sym", sym, pre_exp[15]);
    chk("f1_pre15_sv", sv, 1);
    cyc();
    chk("f1_sv_pulse_width", o_sym_valid, 0);
    pre_ticks("f1", 14, 0);
    pay_ticks("f1", 0, 7, -1);
    chk("f1_underrun", o_underrun, 0);
    gap_ticks("f1");

    // Frame 2: missing bit on payload tick 3, repeated start mid-payload.
    start_frame("f2");
    pre_ticks("f2", 15, 0);
    pay_ticks("f2", 0, 3, 3);
    chk("f2_underrun_set", o_underrun, 1);
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    pay_ticks("f2", 4, 7, -1);
    chk("f2_underrun_sticky", o_underrun, 1);
    gap_ticks("f2");
    repeat (4) cyc();
    chk("f2_no_queued_start", o_busy, 0);
    chk("f2_underrun_idle", o_underrun, 1);

    // Frame 3: enable dropped for 10 clocks mid-preamble.
    start_frame("f3");
    chk("f3_underrun_cleared", o_underrun, 0);
    pre_ticks("f3", 15, 11);
    seen = 1'b0;
    i_enable = 1'b0;
    i_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen = seen | o_sym_valid;
    end
    chk("f3_frozen_no_sv", seen, 0);
    chk("f3_frozen_busy", o_busy, 1);
    i_enable = 1'b1;
    i_valid  = 1'b0;
    pre_ticks("f3", 10, 0);
    pay_ticks("f3", 0, 7, -1);
    gap_ticks("f3");

    // Frame 4: start coinciding with a tick in IDLE emits nothing on that tick.
    repeat (2) cyc();
    i_start = 1'b1;
    i_valid = 1'b1;
    cyc();
    i_start = 1'b0;
    i_valid = 1'b0;
    chk("f4_no_sym_on_start_tick", o_sym_valid, 0);
    cyc();
    chk("f4_busy", o_busy, 1);
    pre_ticks("f4", 15, 0);
    pay_ticks("f4", 0, 2, -1);

    // Reset mid-payload aborts without o_done.
    repeat (2) cyc();
    i_reset = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_sym_valid", o_sym_valid, 0);
    chk("rst_mid_symbol", o_symbol, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_underrun", o_underrun, 0);
    repeat (3) cyc();
    i_reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_tick(1'b1, 1'b1, rq, r, sv, sym);
      seen = seen | sv | o_done | o_busy;
    end
    chk("rst_mid_quiet_after", seen, 0);

    // Frame 5: full preamble after the abort.
    start_frame("f5");
    pre_ticks("f5", 15, 0);
    pay_ticks("f5", 0, 7, -1);
    gap_ticks("f5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
